// File: rtl/gate_bist_checker.sv
// Built-in self-test responder for the 2-input gate library.
// It sweeps a/b through all four vectors, samples the six gate outputs, and reports the mismatches.
module gate_bist_checker #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned PASSES        = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic [5:0] gate_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] err_mask,
    output logic [7:0] err_count,
    output logic       fail_valid,
    output logic [1:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0] PASS_LAST   = 8'(PASSES - 1);

    state_t     state_q;
    logic [1:0] vec_q;
    logic [7:0] pass_cnt_q;
    logic [3:0] settle_cnt_q;
    logic       a_q;
    logic       b_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [5:0] err_mask_q;
    logic [7:0] err_count_q;
    logic       fail_valid_q;
    logic [1:0] fail_vec_q;

    logic [5:0] expected_d;
    logic [5:0] mismatch_d;
    logic [2:0] mism_cnt_d;
    logic [8:0] count_sum_d;
    logic [5:0] err_mask_d;
    logic [7:0] err_count_d;
    logic       fail_valid_d;
    logic [1:0] fail_vec_d;
    logic [1:0] vec_d;
    logic       last_vec_d;

    // Result update for the current vector. It is only committed in SAMPLE.
    always_comb begin
        expected_d = {~(vec_q[1] ^ vec_q[0]), ~(vec_q[1] | vec_q[0]), ~(vec_q[1] & vec_q[0]),
                      vec_q[1] ^ vec_q[0], vec_q[1] | vec_q[0], vec_q[1] & vec_q[0]};
        mismatch_d = gate_in ^ expected_d;
        mism_cnt_d = '0;
        for (int i = 0; i < 6; i++) begin
            mism_cnt_d = mism_cnt_d + 3'(mismatch_d[i]);
        end
        count_sum_d  = {1'b0, err_count_q} + {6'b0, mism_cnt_d};
        err_count_d  = count_sum_d[8] ? 8'hFF : count_sum_d[7:0];
        err_mask_d   = err_mask_q | mismatch_d;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        if ((mismatch_d != 6'b0) && !fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
        end
        vec_d      = vec_q + 2'd1;
        last_vec_d = (vec_q == 2'd3) && (pass_cnt_q == PASS_LAST);
    end

    // Sequencer. All outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            pass_cnt_q   <= '0;
            settle_cnt_q <= '0;
            a_q          <= 1'b0;
            b_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_mask_q   <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= SETTLE;
                        vec_q        <= '0;
                        pass_cnt_q   <= '0;
                        settle_cnt_q <= '0;
                        a_q          <= 1'b0;
                        b_q          <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_mask_q   <= '0;
                        err_count_q  <= '0;
                        fail_valid_q <= 1'b0;
                        fail_vec_q   <= '0;
                    end
                end
                SETTLE: begin
                    settle_cnt_q <= settle_cnt_q + 4'd1;
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_q <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    err_mask_q   <= err_mask_d;
                    err_count_q  <= err_count_d;
                    fail_valid_q <= fail_valid_d;
                    fail_vec_q   <= fail_vec_d;
                    if (last_vec_d) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_d == 8'd0);
                    end else begin
                        state_q      <= SETTLE;
                        settle_cnt_q <= '0;
                        vec_q        <= vec_d;
                        a_q          <= vec_d[1];
                        b_q          <= vec_d[0];
                        if (vec_q == 2'd3) begin
                            pass_cnt_q <= pass_cnt_q + 8'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_mask   = err_mask_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Bench for gate_bist_checker. A run-level model predicts every output on every cycle,
// and directed literals pin the headline results of each scenario.
module tb_gate_bist_checker;

    localparam int S     = 2;
    localparam int P     = 1;
    localparam int NCYC  = 4 * P * (S + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstN;
    logic       start;
    logic       start20;
    logic [1:0] mode;

    logic       aOut, bOut, busy, done, passO, failValid;
    logic [5:0] gateIn, errMask;
    logic [7:0] errCount;
    logic [1:0] failVec;

    logic       aOut20, bOut20, busy20, done20, pass20, failValid20;
    logic [5:0] gateIn20, errMask20;
    logic [7:0] errCount20;
    logic [1:0] failVec20;

    typedef struct {
        logic [5:0] mask;
        int         count;
        logic       fv;
        logic [1:0] fvec;
    } res_t;

    function automatic logic [5:0] idealGates(logic a, logic b);
        int ia = int'(a);
        int ib = int'(b);
        logic [5:0] r;
        r[0] = (ia * ib == 1);
        r[1] = (ia + ib >= 1);
        r[2] = (ia + ib == 1);
        r[3] = !r[0];
        r[4] = !r[1];
        r[5] = !r[2];
        return r;
    endfunction

    // mode 0: ideal gates, 1: XOR stuck at 0, 2: every output inverted
    function automatic logic [5:0] gateModel(logic [1:0] m, logic a, logic b);
        logic [5:0] ideal = idealGates(a, b);
        case (m)
            2'd1:    return ideal & 6'b111011;
            2'd2:    return ~ideal;
            default: return ideal;
        endcase
    endfunction

    function automatic res_t accumulate(logic [1:0] m, int nvec);
        res_t r;
        r.mask = '0;
        r.count = 0;
        r.fv = 1'b0;
        r.fvec = '0;
        for (int t = 0; t < nvec; t++) begin
            logic a = ((t % 4) / 2) == 1;
            logic b = (t % 2) == 1;
            logic [5:0] diff = gateModel(m, a, b) ^ idealGates(a, b);
            r.mask |= diff;
            r.count += $countones(diff);
            if (r.count > 255) r.count = 255;
            if (diff != 0 && !r.fv) begin
                r.fv = 1'b1;
                r.fvec = {a, b};
            end
        end
        return r;
    endfunction

    assign gateIn   = gateModel(mode, aOut, bOut);
    assign gateIn20 = gateModel(2'd2, aOut20, bOut20);

    gate_bist_checker #(.SETTLE_CYCLES(S), .PASSES(P)) dut (
        .clk(clk), .rst_n(rstN), .start(start), .a_out(aOut), .b_out(bOut),
        .gate_in(gateIn), .busy(busy), .done(done), .pass(passO),
        .err_mask(errMask), .err_count(errCount), .fail_valid(failValid), .fail_vec(failVec)
    );

    gate_bist_checker #(.SETTLE_CYCLES(S), .PASSES(20)) dut20 (
        .clk(clk), .rst_n(rstN), .start(start20), .a_out(aOut20), .b_out(bOut20),
        .gate_in(gateIn20), .busy(busy20), .done(done20), .pass(pass20),
        .err_mask(errMask20), .err_count(errCount20), .fail_valid(failValid20), .fail_vec(failVec20)
    );

    int checkCount = 0;
    int passCount  = 0;
    bit checkEnable = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
        end
    endtask

    // Run-level model: tracks only whether a run is active and when it started.
    int         cyc = 0;
    bit         mBusy = 1'b0;
    bit         mDone = 1'b0;
    int         runStart = 0;
    logic [1:0] runMode = 2'd0;

    always @(posedge clk) begin
        cyc++;
        if (rstN !== 1'b1) begin
            mBusy = 1'b0;
            mDone = 1'b0;
        end else if (!mBusy && start === 1'b1) begin
            mBusy = 1'b1;
            mDone = 1'b0;
            runStart = cyc;
            runMode = mode;
        end else if (mBusy && (cyc - runStart == NCYC)) begin
            mBusy = 1'b0;
            mDone = 1'b1;
        end
    end

    always @(negedge clk) begin
        res_t r;
        logic [1:0] expAb;
        logic expBusy, expDone, expPass;
        int e;
        if (checkEnable) begin
            expBusy = 1'b0;
            expDone = 1'b0;
            expPass = 1'b0;
            if (mBusy) begin
                e = cyc - runStart;
                expAb = 2'((e / (S + 1)) % 4);
                r = accumulate(runMode, e / (S + 1));
                expBusy = 1'b1;
            end else if (mDone) begin
                expAb = 2'b11;
                r = accumulate(runMode, 4 * P);
                expDone = 1'b1;
                expPass = (r.count == 0);
            end else begin
                expAb = 2'b00;
                r = accumulate(2'd0, 0);
            end
            checkOutput("ab", {30'b0, aOut, bOut}, {30'b0, expAb});
            checkOutput("busy", {31'b0, busy}, {31'b0, expBusy});
            checkOutput("done", {31'b0, done}, {31'b0, expDone});
            checkOutput("pass", {31'b0, passO}, {31'b0, expPass});
            checkOutput("errMask", {26'b0, errMask}, {26'b0, r.mask});
            checkOutput("errCount", {24'b0, errCount}, r.count);
            checkOutput("failValid", {31'b0, failValid}, {31'b0, r.fv});
            checkOutput("failVec", {30'b0, failVec}, {30'b0, r.fvec});
        end
    end

    task automatic applyStimulus(input logic [1:0] m, input bit holdStart, output int lat);
        int startCyc;
        mode = m;
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #1 startCyc = cyc;
        checkOutput("acceptBusy", {31'b0, busy}, 1);
        checkOutput("acceptDone", {31'b0, done}, 0);
        checkOutput("acceptCount", {24'b0, errCount}, 0);
        #1 if (!holdStart) start = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - startCyc;
                break;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int lat;
        int s20;
        rstN = 1'b0;
        start = 1'b0;
        start20 = 1'b0;
        mode = 2'd0;
        @(posedge clk);
        #2 checkEnable = 1'b1;
        @(posedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        checkOutput("rstBusy", {31'b0, busy}, 0);
        checkOutput("rstCount", {24'b0, errCount}, 0);

        applyStimulus(2'd0, 1'b0, lat);
        checkOutput("idealLatency", lat, 12);
        checkOutput("idealPass", {31'b0, passO}, 1);
        checkOutput("idealMask", {26'b0, errMask}, 0);
        checkOutput("idealFailValid", {31'b0, failValid}, 0);

        applyStimulus(2'd1, 1'b0, lat);
        checkOutput("xorLatency", lat, 12);
        checkOutput("xorPass", {31'b0, passO}, 0);
        checkOutput("xorMask", {26'b0, errMask}, 6'b000100);
        checkOutput("xorCount", {24'b0, errCount}, 2);
        checkOutput("xorFailValid", {31'b0, failValid}, 1);
        checkOutput("xorFailVec", {30'b0, failVec}, 2'b01);

        applyStimulus(2'd0, 1'b0, lat);
        checkOutput("rerunLatency", lat, 12);
        checkOutput("rerunPass", {31'b0, passO}, 1);

        applyStimulus(2'd2, 1'b0, lat);
        checkOutput("invMask", {26'b0, errMask}, 6'b111111);
        checkOutput("invCount", {24'b0, errCount}, 24);
        checkOutput("invFailVec", {30'b0, failVec}, 2'b00);

        applyStimulus(2'd0, 1'b1, lat);
        checkOutput("holdStartLatency", lat, 12);

        // Reset lands while vector 10 is on the gates.
        mode = 2'd0;
        @(posedge clk);
        #2 start = 1'b1;
        @(posedge clk);
        #2 start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rstN = 1'b0;
        checkOutput("preResetAb", {30'b0, aOut, bOut}, 2'b10);
        @(posedge clk);
        #2 rstN = 1'b1;
        @(negedge clk);
        checkOutput("midResetBusy", {31'b0, busy}, 0);
        checkOutput("midResetAb", {30'b0, aOut, bOut}, 0);
        applyStimulus(2'd0, 1'b0, lat);
        checkOutput("postResetLatency", lat, 12);
        checkOutput("postResetPass", {31'b0, passO}, 1);

        @(posedge clk);
        #2 start20 = 1'b1;
        @(posedge clk);
        #1 s20 = cyc;
        #1 start20 = 1'b0;
        lat = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done20 === 1'b1) begin
                lat = cyc - s20;
                break;
            end
        end
        checkOutput("p20Latency", lat, 240);
        checkOutput("p20Count", {24'b0, errCount20}, 255);
        checkOutput("p20Mask", {26'b0, errMask20}, 6'b111111);
        checkOutput("p20FailVec", {30'b0, failVec20}, 2'b00);
        checkOutput("p20Pass", {31'b0, pass20}, 0);
        checkOutput("p20Busy", {31'b0, busy20}, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/gate_bist_checker.md
Name: gate_bist_checker

Overview:
- Synthesizable self-test responder for the 2-input gate library (and/or/xor/nand/nor/xnor).
- Drives an exhaustive a/b sweep into the gates under test. Samples their six outputs after a settle interval and compares each against the expected truth table.
- Accumulates mismatch results and reports pass/fail through a start/busy/done handshake.
- Moves the sweep-and-check job into hardware so gate checks run on silicon or in any top-level simulation without a bench-side monitor.

Parameters:
- SETTLE_CYCLES, 2: cycles a/b are held before sampling. Legal range 1..15.
- PASSES, 1: number of full 4-vector sweeps per run. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  run request; honoured only in IDLE or DONE
- a_out  output  1  stimulus a to all gates under test
- b_out  output  1  stimulus b to all gates under test
- gate_in  input  6  gate outputs: bit0 AND, bit1 OR, bit2 XOR, bit3 NAND, bit4 NOR, bit5 XNOR
- busy  output  1  sweep in progress
- done  output  1  run complete; results valid while high
- pass  output  1  1 when done and err_count==0
- err_mask  output  6  sticky per-gate mismatch flags, same bit order as gate_in
- err_count  output  8  total bit mismatches, saturating at 255
- fail_valid  output  1  at least one mismatch has been recorded
- fail_vec  output  2  {a,b} of the first vector that mismatched

Behaviour:
- Reset (rst_n=0 at a clock edge), from any state including mid-sweep:
  - state=IDLE.
  - a_out=0, b_out=0, busy=0, done=0, pass=0.
  - err_mask=0, err_count=0, fail_valid=0, fail_vec=0.
  - Internal vec, pass and settle counters cleared.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, or DONE, with start=1 at an edge:
  - Next state SETTLE.
  - vec=0, pass counter=0, settle count=0.
  - All result outputs cleared; done=0, busy=1.
- IDLE, or DONE, with start=0: state and outputs hold.
- start while busy is ignored. It neither restarts nor extends the run.
- Stimulus: a_out=vec[1], b_out=vec[0], both registered. Sweep order per pass is 00, 01, 10, 11.
- SETTLE:
  - settle count increments each cycle.
  - After SETTLE_CYCLES cycles in SETTLE, next state is SAMPLE.
  - gate_in is not examined during SETTLE.
- SAMPLE (exactly 1 cycle):
  - Expected value for vector (a,b): {~(a^b), ~(a|b), ~(a&b), a^b, a|b, a&b}.
  - mismatch = gate_in XOR expected.
  - err_mask |= mismatch.
  - err_count += popcount(mismatch), saturating at 255 with no wrap.
  - If mismatch≠0 and fail_valid=0: fail_vec={a,b}, fail_valid=1.
- Leaving SAMPLE:
  - If vec==3 and pass counter==PASSES-1: next state DONE.
  - Otherwise vec increments with 3→0 wrap. The pass counter increments on the wrap. Next state SETTLE with settle count=0.
- DONE:
  - busy=0, done=1, pass=(err_count==0).
  - a_out/b_out hold the last vector (1,1).
- Latency:
  - Each vector takes SETTLE_CYCLES+1 cycles.
  - If start is accepted at edge k, done rises at edge k+4·PASSES·(SETTLE_CYCLES+1).
  - Defaults: done rises 12 cycles after the start edge.
- busy and done are never high together.
- pass is 0 whenever done=0.

Test Plan:
- Ideal gates wired to a_out/b_out, defaults, start pulse:
  - a_out/b_out step 00,01,10,11, each held 3 cycles.
  - done rises at start edge+12 with pass=1, err_mask=0, err_count=0, fail_valid=0.
- XOR output stuck at 0:
  - done with pass=0, err_mask=6'b000100, err_count=2.
  - fail_valid=1, fail_vec=2'b01.
- All six gate outputs inverted:
  - err_mask=6'b111111, err_count=24, fail_vec=2'b00.
- All six gate outputs inverted, PASSES=20:
  - 480 raw mismatches, so err_count saturates at 255.
  - done rises at start edge+240.
- start held high during busy: completion time is unchanged (edge+12).
- rst_n=0 for one edge during vector 10: every output returns to its reset value. A fresh start then completes normally in 12 cycles.
- From DONE with errors recorded, start pulse:
  - Results clear on the next edge and busy=1.
  - The new run with ideal gates ends with pass=1.
